// File: rtl/prio_encoder_rr_if.sv
// Valid/ready bundle for the registered priority encoder.
// The slave side is the encoder; the master side is whoever feeds requests and drains results.
interface prio_encoder_rr_if #(
   parameter int N = 8
);
   localparam int W = (N > 1) ? $clog2(N) : 1;

   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_req;
   logic         in_mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_idx;
   logic         out_none;
   logic         out_multi;

   modport slave (
      input  in_valid, in_req, in_mode, out_ready,
      output in_ready, out_valid, out_idx, out_none, out_multi
   );

   modport master (
      output in_valid, in_req, in_mode, out_ready,
      input  in_ready, out_valid, out_idx, out_none, out_multi
   );
endinterface

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) encoder with fixed (MSB-first) or round-robin priority,
// plus zero/multi-hot flags, behind a one-entry valid/ready output register.
module prio_encoder_rr #(
   parameter  int N = 8,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input logic              clk,
   input logic              rst,
   prio_encoder_rr_if.slave bus
);

   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_idx_q,   out_idx_d;
   logic         out_none_q,  out_none_d;
   logic         out_multi_q, out_multi_d;
   logic [W-1:0] rr_ptr_q,    rr_ptr_d;

   logic         accept;
   logic         drain;
   logic         req_zero;
   logic [W-1:0] fixed_idx;
   logic [W-1:0] rr_idx;
   logic         rr_hit;
   logic [W-1:0] grant_idx;
   int           j;

   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign drain        = out_valid_q && bus.out_ready;
   assign req_zero     = (bus.in_req == '0);

   // Ascending scan: the last set bit seen is the highest one.
   always_comb begin
      fixed_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (bus.in_req[i]) fixed_idx = W'(i);
      end
   end

   // Search starts one past the last round-robin grant and wraps through bit 0.
   always_comb begin
      rr_idx = '0;
      rr_hit = 1'b0;
      j      = 0;
      for (int k = 1; k <= N; k++) begin
         j = int'(rr_ptr_q) + k;
         if (j >= N) j = j - N;
         if (!rr_hit && bus.in_req[j]) begin
            rr_idx = W'(j);
            rr_hit = 1'b1;
         end
      end
   end

   assign grant_idx = req_zero ? '0 : (bus.in_mode ? rr_idx : fixed_idx);

   always_comb begin
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      out_none_d  = out_none_q;
      out_multi_d = out_multi_q;
      rr_ptr_d    = rr_ptr_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_idx_d   = grant_idx;
         out_none_d  = req_zero;
         out_multi_d = ($countones(bus.in_req) > 1);
         if (bus.in_mode && !req_zero) rr_ptr_d = grant_idx;
      end else if (drain) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_none_q  <= 1'b0;
         out_multi_q <= 1'b0;
         rr_ptr_q    <= W'(N - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         out_none_q  <= out_none_d;
         out_multi_q <= out_multi_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.out_none  = out_none_q;
   assign bus.out_multi = out_multi_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Self-checking bench for prio_encoder_rr: directed scenarios plus a randomized run
// compared against an arithmetic reference model of the grant rules.
module tb_prio_encoder_rr;
   localparam int N = 8;
   localparam int W = $clog2(N);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   prio_encoder_rr_if #(.N(N)) bus ();

   prio_encoder_rr #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // reference model state
   logic         m_valid;
   logic [W-1:0] m_idx;
   logic         m_none;
   logic         m_multi;
   int           m_ptr;
   logic         obs_ready;
   logic         exp_ready;

   function automatic int highest_bit(input logic [N-1:0] r);
      int v;
      v = int'(r) + 1;
      return $clog2(v) - 1;
   endfunction

   function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
      logic [2*N-1:0] dbl;
      logic [N-1:0]   rot;
      logic [N-1:0]   low;
      int             start;
      start = (ptr + 1) % N;
      dbl   = {r, r};
      rot   = N'(dbl >> start);
      low   = rot & (~rot + 1'b1);
      return (start + $clog2(low)) % N;
   endfunction

   function automatic int popcnt(input logic [N-1:0] r);
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(r[i]);
      return c;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_idx   = '0;
      m_none  = 1'b0;
      m_multi = 1'b0;
      m_ptr   = N - 1;
   endtask

   // Drive one cycle, update the model, return #1 after the capturing edge.
   task automatic drive(input logic v, input logic [N-1:0] r, input logic m, input logic ordy);
      int g;
      bus.in_valid  = v;
      bus.in_req    = r;
      bus.in_mode   = m;
      bus.out_ready = ordy;
      #1;
      obs_ready = bus.in_ready;
      exp_ready = !m_valid || ordy;
      if (v && exp_ready) begin
         if (r == '0) g = 0;
         else if (m) g = rr_pick(r, m_ptr);
         else g = highest_bit(r);
         m_valid = 1'b1;
         m_idx   = W'(g);
         m_none  = (r == '0);
         m_multi = (popcnt(r) > 1);
         if (m && r != '0) m_ptr = g;
      end else if (m_valid && ordy) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset();
      tests_run++;
      if ({bus.out_valid, bus.out_idx, bus.out_none, bus.out_multi} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs got v=%b idx=%0d none=%b multi=%b want all zero",
                  bus.out_valid, bus.out_idx, bus.out_none, bus.out_multi);
      end
      tests_run++;
      if (bus.in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_onehot_sweep();
      for (int k = 0; k < N; k++) begin
         logic [N-1:0] r;
         r = '0;
         r[k] = 1'b1;
         drive(1'b1, r, 1'b0, 1'b1);
         tests_run++;
         if ({bus.out_valid, bus.out_idx, bus.out_none, bus.out_multi} !== {1'b1, W'(k), 2'b00}) begin
            tests_failed++;
            $display("FAIL onehot_%0d got v=%b idx=%0d none=%b multi=%b want v=1 idx=%0d none=0 multi=0",
                     k, bus.out_valid, bus.out_idx, bus.out_none, bus.out_multi, k);
         end
      end
   endtask

   task automatic test_fixed_priority();
      drive(1'b1, 8'b1001_0010, 1'b0, 1'b1);
      tests_run++;
      if ({bus.out_valid, bus.out_idx, bus.out_none, bus.out_multi} !== {1'b1, 3'd7, 2'b01}) begin
         tests_failed++;
         $display("FAIL fixed_92 got idx=%0d none=%b multi=%b want idx=7 none=0 multi=1",
                  bus.out_idx, bus.out_none, bus.out_multi);
      end
      drive(1'b1, 8'b0001_0110, 1'b0, 1'b1);
      tests_run++;
      if ({bus.out_valid, bus.out_idx, bus.out_none, bus.out_multi} !== {1'b1, 3'd4, 2'b01}) begin
         tests_failed++;
         $display("FAIL fixed_16 got idx=%0d none=%b multi=%b want idx=4 none=0 multi=1",
                  bus.out_idx, bus.out_none, bus.out_multi);
      end
   endtask

   task automatic test_rr_fairness();
      apply_reset();
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 8'hFF, 1'b1, 1'b1);
         tests_run++;
         if ({bus.out_valid, bus.out_idx, bus.out_multi} !== {1'b1, W'(k % N), 1'b1}) begin
            tests_failed++;
            $display("FAIL rr_ff_%0d got v=%b idx=%0d multi=%b want v=1 idx=%0d multi=1",
                     k, bus.out_valid, bus.out_idx, bus.out_multi, k % N);
         end
      end
      drive(1'b1, 8'b0010_0001, 1'b1, 1'b1);
      tests_run++;
      if (bus.out_idx !== 3'd5) begin
         tests_failed++;
         $display("FAIL rr_21_first got idx=%0d want 5", bus.out_idx);
      end
      drive(1'b1, 8'b0010_0001, 1'b1, 1'b1);
      tests_run++;
      if (bus.out_idx !== 3'd0) begin
         tests_failed++;
         $display("FAIL rr_21_wrap got idx=%0d want 0", bus.out_idx);
      end
   endtask

   // Pointer is 0 on entry (last RR grant was bit 0).
   task automatic test_zero_vector();
      drive(1'b1, 8'h00, 1'b1, 1'b1);
      tests_run++;
      if ({bus.out_valid, bus.out_idx, bus.out_none, bus.out_multi} !== {1'b1, 3'd0, 2'b10}) begin
         tests_failed++;
         $display("FAIL zero_rr got idx=%0d none=%b multi=%b want idx=0 none=1 multi=0",
                  bus.out_idx, bus.out_none, bus.out_multi);
      end
      drive(1'b1, 8'h00, 1'b0, 1'b1);
      tests_run++;
      if ({bus.out_valid, bus.out_idx, bus.out_none, bus.out_multi} !== {1'b1, 3'd0, 2'b10}) begin
         tests_failed++;
         $display("FAIL zero_fixed got idx=%0d none=%b multi=%b want idx=0 none=1 multi=0",
                  bus.out_idx, bus.out_none, bus.out_multi);
      end
      drive(1'b1, 8'hFF, 1'b0, 1'b1);
      drive(1'b1, 8'hFF, 1'b1, 1'b1);
      tests_run++;
      if ({bus.out_idx, bus.out_none} !== {3'd1, 1'b0}) begin
         tests_failed++;
         $display("FAIL zero_ptr_kept got idx=%0d none=%b want idx=1 none=0",
                  bus.out_idx, bus.out_none);
      end
   endtask

   task automatic test_backpressure();
      logic [N-1:0] reqs [5] = '{8'h10, 8'h01, 8'h02, 8'h80, 8'h03};
      drive(1'b0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, reqs[k], 1'b0, 1'b0);
         tests_run++;
         if (obs_ready !== (k == 0)) begin
            tests_failed++;
            $display("FAIL bp_in_ready_%0d got %b want %b", k, obs_ready, (k == 0));
         end
         tests_run++;
         if ({bus.out_valid, bus.out_idx, bus.out_none, bus.out_multi} !== {1'b1, 3'd4, 2'b00}) begin
            tests_failed++;
            $display("FAIL bp_hold_%0d got v=%b idx=%0d none=%b multi=%b want v=1 idx=4 none=0 multi=0",
                     k, bus.out_valid, bus.out_idx, bus.out_none, bus.out_multi);
         end
      end
      drive(1'b1, 8'h40, 1'b0, 1'b1);
      tests_run++;
      if ({obs_ready, bus.out_valid, bus.out_idx} !== {1'b1, 1'b1, 3'd6}) begin
         tests_failed++;
         $display("FAIL bp_release got ready=%b v=%b idx=%0d want ready=1 v=1 idx=6",
                  obs_ready, bus.out_valid, bus.out_idx);
      end
      drive(1'b0, '0, 1'b0, 1'b1);
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_drain got v=%b want 0", bus.out_valid);
      end
   endtask

   task automatic test_reset_midstream();
      apply_reset();
      for (int k = 0; k < 4; k++) drive(1'b1, 8'hFF, 1'b1, 1'b1);
      tests_run++;
      if ({bus.out_valid, bus.out_idx} !== {1'b1, 3'd3}) begin
         tests_failed++;
         $display("FAIL mid_setup got v=%b idx=%0d want v=1 idx=3", bus.out_valid, bus.out_idx);
      end
      rst = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_req    = 8'hFF;
      bus.in_mode   = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_rst_valid got %b want 0", bus.out_valid);
      end
      drive(1'b1, 8'hFF, 1'b1, 1'b1);
      tests_run++;
      if ({bus.out_valid, bus.out_idx} !== {1'b1, 3'd0}) begin
         tests_failed++;
         $display("FAIL mid_rst_grant got v=%b idx=%0d want v=1 idx=0", bus.out_valid, bus.out_idx);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         logic [N-1:0] r;
         int sel;
         sel = $urandom_range(0, 3);
         if (sel == 0) r = '0;
         else if (sel == 1) r = N'(1) << $urandom_range(0, N - 1);
         else r = N'($urandom);
         drive(1'($urandom_range(0, 3) != 0), r, 1'($urandom), 1'($urandom_range(0, 2) != 0));
         tests_run++;
         if (obs_ready !== exp_ready) begin
            tests_failed++;
            $display("FAIL rand_ready_%0d got %b want %b", n, obs_ready, exp_ready);
         end
         tests_run++;
         if (bus.out_valid !== m_valid ||
             (m_valid && {bus.out_idx, bus.out_none, bus.out_multi} !== {m_idx, m_none, m_multi})) begin
            tests_failed++;
            $display("FAIL rand_out_%0d got v=%b idx=%0d none=%b multi=%b want v=%b idx=%0d none=%b multi=%b",
                     n, bus.out_valid, bus.out_idx, bus.out_none, bus.out_multi,
                     m_valid, m_idx, m_none, m_multi);
         end
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_req    = '0;
      bus.in_mode   = 1'b0;
      bus.out_ready = 1'b0;
      model_reset();
      test_reset();
      test_onehot_sweep();
      test_fixed_priority();
      test_rr_fairness();
      test_zero_vector();
      test_backpressure();
      test_reset_midstream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
